// File: rtl/dbf_seq_ctrl.sv
// -----------------------------------------------------------------------------
// dbf_seq_ctrl
// Scanline sequencer for a digital beamformer. For each scanline of a frame it
// opens a transmit window, waits a settle interval, opens a receive window in
// which it sweeps the shared delay LUT address, then waits in an inter-line gap
// until both a minimum gap time has elapsed and the beamsum consumer has
// acknowledged the line. All outputs are registered.
//
// Ports
//   clk          in   sole clock, rising edge
//   rst          in   asynchronous active-high reset
//   frame_start  in   single-cycle request to begin a frame (honoured in IDLE)
//   abort        in   immediate frame termination request
//   line_ack     in   consumer has accepted the current line (sampled in GAP)
//   tx_en        out  transmit window to all DBF channels
//   start        out  receive/beamform window to all DBF channels
//   dbf_lut_addr out  delay LUT address, common to all channels
//   dbf_lut_we   out  LUT access strobe, common to all channels
//   line_idx     out  current scanline index
//   line_done    out  one-cycle pulse on the first GAP cycle of each line
//   frame_done   out  one-cycle pulse on the first IDLE cycle after the last line
//   aborted      out  one-cycle pulse acknowledging an abort
//   busy         out  high in every state other than IDLE
// -----------------------------------------------------------------------------
module dbf_seq_ctrl #(
    parameter int ADDR_WD    = 12,
    parameter int LINE_WD    = 8,
    parameter int TX_LEN     = 64,
    parameter int SETTLE_LEN = 16,
    parameter int RX_LEN     = 2048,
    parameter int GAP_LEN    = 32,
    parameter int NUM_LINES  = 128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_start,
    input  logic               abort,
    input  logic               line_ack,
    output logic               tx_en,
    output logic               start,
    output logic [ADDR_WD-1:0] dbf_lut_addr,
    output logic               dbf_lut_we,
    output logic [LINE_WD-1:0] line_idx,
    output logic               line_done,
    output logic               frame_done,
    output logic               aborted,
    output logic               busy
);

    // One shared down-counter serves every timed phase; it must hold RX_LEN-1.
    localparam int CNT_WD = (ADDR_WD > 16) ? ADDR_WD : 16;

    // Counter reload values: each phase runs while the counter walks down to 0.
    localparam logic [CNT_WD-1:0]  TX_LOAD     = CNT_WD'(TX_LEN - 1);
    localparam logic [CNT_WD-1:0]  SETTLE_LOAD = CNT_WD'(SETTLE_LEN - 1);
    localparam logic [CNT_WD-1:0]  RX_LOAD     = CNT_WD'(RX_LEN - 1);
    localparam logic [CNT_WD-1:0]  GAP_LOAD    = CNT_WD'(GAP_LEN - 1);
    localparam logic [LINE_WD-1:0] LAST_LINE   = LINE_WD'(NUM_LINES - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_TX     = 3'd1,
        ST_SETTLE = 3'd2,
        ST_RX     = 3'd3,
        ST_GAP    = 3'd4
    } state_t;

    state_t              state_r;
    logic [CNT_WD-1:0]   cnt_r;
    logic                ack_seen_r;

    // Counter has reached the last cycle of the current phase.
    logic                cnt_zero_s;
    // Consumer acknowledge, either latched earlier in GAP or present now.
    logic                ack_ok_s;

    // Phase-end and acknowledge qualifiers for the sequencer.
    always_comb begin
        cnt_zero_s = (cnt_r == {CNT_WD{1'b0}});
        ack_ok_s   = ack_seen_r | line_ack;
    end

    // Sequencer FSM: state, shared counter, sticky ack flag and all outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= {CNT_WD{1'b0}};
            ack_seen_r   <= 1'b0;
            tx_en        <= 1'b0;
            start        <= 1'b0;
            dbf_lut_addr <= {ADDR_WD{1'b0}};
            dbf_lut_we   <= 1'b0;
            line_idx     <= {LINE_WD{1'b0}};
            line_done    <= 1'b0;
            frame_done   <= 1'b0;
            aborted      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            // Status pulses last exactly one cycle unless re-armed below.
            line_done  <= 1'b0;
            frame_done <= 1'b0;
            aborted    <= 1'b0;

            if (abort && (state_r != ST_IDLE)) begin
                // Abort wins over any phase end, so line/frame completion
                // pulses are suppressed in the same cycle.
                state_r      <= ST_IDLE;
                cnt_r        <= {CNT_WD{1'b0}};
                ack_seen_r   <= 1'b0;
                tx_en        <= 1'b0;
                start        <= 1'b0;
                dbf_lut_addr <= {ADDR_WD{1'b0}};
                dbf_lut_we   <= 1'b0;
                line_idx     <= {LINE_WD{1'b0}};
                aborted      <= 1'b1;
                busy         <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        // abort in IDLE blocks a simultaneous frame_start.
                        if (frame_start && !abort) begin
                            state_r <= ST_TX;
                            cnt_r   <= TX_LOAD;
                            tx_en   <= 1'b1;
                            busy    <= 1'b1;
                        end else begin
                            state_r <= ST_IDLE;
                            cnt_r   <= {CNT_WD{1'b0}};
                            tx_en   <= 1'b0;
                            busy    <= 1'b0;
                        end
                        ack_seen_r   <= 1'b0;
                        start        <= 1'b0;
                        dbf_lut_addr <= {ADDR_WD{1'b0}};
                        dbf_lut_we   <= 1'b0;
                        line_idx     <= {LINE_WD{1'b0}};
                    end

                    ST_TX: begin
                        if (cnt_zero_s) begin
                            state_r <= ST_SETTLE;
                            cnt_r   <= SETTLE_LOAD;
                            tx_en   <= 1'b0;
                        end else begin
                            cnt_r   <= cnt_r - CNT_WD'(1);
                            tx_en   <= 1'b1;
                        end
                    end

                    ST_SETTLE: begin
                        if (cnt_zero_s) begin
                            state_r      <= ST_RX;
                            cnt_r        <= RX_LOAD;
                            start        <= 1'b1;
                            dbf_lut_we   <= 1'b1;
                            dbf_lut_addr <= {ADDR_WD{1'b0}};
                        end else begin
                            cnt_r        <= cnt_r - CNT_WD'(1);
                        end
                    end

                    ST_RX: begin
                        if (cnt_zero_s) begin
                            // Address returns to 0 on exit rather than
                            // incrementing, so a full-range sweep never wraps.
                            state_r      <= ST_GAP;
                            cnt_r        <= GAP_LOAD;
                            start        <= 1'b0;
                            dbf_lut_we   <= 1'b0;
                            dbf_lut_addr <= {ADDR_WD{1'b0}};
                            line_done    <= 1'b1;
                        end else begin
                            cnt_r        <= cnt_r - CNT_WD'(1);
                            dbf_lut_addr <= dbf_lut_addr + ADDR_WD'(1);
                        end
                    end

                    ST_GAP: begin
                        if (cnt_zero_s && ack_ok_s) begin
                            ack_seen_r <= 1'b0;
                            if (line_idx == LAST_LINE) begin
                                state_r    <= ST_IDLE;
                                cnt_r      <= {CNT_WD{1'b0}};
                                line_idx   <= {LINE_WD{1'b0}};
                                frame_done <= 1'b1;
                                busy       <= 1'b0;
                            end else begin
                                state_r    <= ST_TX;
                                cnt_r      <= TX_LOAD;
                                line_idx   <= line_idx + LINE_WD'(1);
                                tx_en      <= 1'b1;
                            end
                        end else begin
                            // Minimum gap counts down, then holds at 0 while
                            // the acknowledge is still outstanding.
                            ack_seen_r <= ack_ok_s;
                            if (cnt_zero_s) begin
                                cnt_r <= {CNT_WD{1'b0}};
                            end else begin
                                cnt_r <= cnt_r - CNT_WD'(1);
                            end
                        end
                    end

                    default: begin
                        state_r      <= ST_IDLE;
                        cnt_r        <= {CNT_WD{1'b0}};
                        ack_seen_r   <= 1'b0;
                        tx_en        <= 1'b0;
                        start        <= 1'b0;
                        dbf_lut_addr <= {ADDR_WD{1'b0}};
                        dbf_lut_we   <= 1'b0;
                        line_idx     <= {LINE_WD{1'b0}};
                        busy         <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dbf_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dbf_seq_ctrl
// Directed bench for dbf_seq_ctrl with small parameters
// (TX 4, SETTLE 2, RX 8, GAP 3, 2 lines, 3-bit address). Cycle 0 is the cycle
// in which frame_start is driven; outputs are sampled 1 time unit after each
// rising edge and compared with hand-derived schedules.
// -----------------------------------------------------------------------------
module tb_dbf_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       frame_start;
    logic       abort;
    logic       line_ack;
    logic       tx_en;
    logic       start;
    logic [2:0] dbf_lut_addr;
    logic       dbf_lut_we;
    logic [7:0] line_idx;
    logic       line_done;
    logic       frame_done;
    logic       aborted;
    logic       busy;

    int n_cmp;
    int n_bad;
    int cyc;

    dbf_seq_ctrl #(
        .ADDR_WD   (3),
        .LINE_WD   (8),
        .TX_LEN    (4),
        .SETTLE_LEN(2),
        .RX_LEN    (8),
        .GAP_LEN   (3),
        .NUM_LINES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .abort       (abort),
        .line_ack    (line_ack),
        .tx_en       (tx_en),
        .start       (start),
        .dbf_lut_addr(dbf_lut_addr),
        .dbf_lut_we  (dbf_lut_we),
        .line_idx    (line_idx),
        .line_done   (line_done),
        .frame_done  (frame_done),
        .aborted     (aborted),
        .busy        (busy)
    );

    // 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; leaves time 1 unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Drive frame_start in cycle 0 and move to cycle 1.
    task automatic start_frame();
        frame_start = 1'b1;
        cyc = 0;
        tick();
        frame_start = 1'b0;
    endtask

    // Every output against the nominal two-line schedule with line_ack high.
    task automatic check_nominal(input int c);
        logic       e_tx;
        logic       e_rx;
        logic [2:0] e_addr;
        e_tx   = ((c >= 1) && (c <= 4)) || ((c >= 18) && (c <= 21));
        e_rx   = ((c >= 7) && (c <= 14)) || ((c >= 24) && (c <= 31));
        e_addr = 3'd0;
        if ((c >= 7) && (c <= 14))  e_addr = 3'(c - 7);
        if ((c >= 24) && (c <= 31)) e_addr = 3'(c - 24);
        check_val($sformatf("c%0d tx_en", c), tx_en, e_tx);
        check_val($sformatf("c%0d start", c), start, e_rx);
        check_val($sformatf("c%0d we", c), dbf_lut_we, e_rx);
        check_val($sformatf("c%0d addr", c), dbf_lut_addr, e_addr);
        check_val($sformatf("c%0d line_done", c), line_done, (c == 15) || (c == 32));
        check_val($sformatf("c%0d frame_done", c), frame_done, c == 35);
        check_val($sformatf("c%0d line_idx", c), line_idx, ((c >= 18) && (c <= 34)) ? 1 : 0);
        check_val($sformatf("c%0d busy", c), busy, (c >= 1) && (c <= 34));
        check_val($sformatf("c%0d aborted", c), aborted, 1'b0);
    endtask

    // Every output must be 0.
    task automatic check_all_zero(input string tag);
        check_val({tag, " tx_en"}, tx_en, 1'b0);
        check_val({tag, " start"}, start, 1'b0);
        check_val({tag, " addr"}, dbf_lut_addr, 3'd0);
        check_val({tag, " we"}, dbf_lut_we, 1'b0);
        check_val({tag, " line_idx"}, line_idx, 8'd0);
        check_val({tag, " line_done"}, line_done, 1'b0);
        check_val({tag, " frame_done"}, frame_done, 1'b0);
        check_val({tag, " aborted"}, aborted, 1'b0);
        check_val({tag, " busy"}, busy, 1'b0);
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        cyc         = 0;
        rst         = 1'b1;
        frame_start = 1'b0;
        abort       = 1'b0;
        line_ack    = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");

        // Nominal frame; frame_start coincides with reset release.
        rst      = 1'b0;
        line_ack = 1'b1;
        start_frame();
        while (cyc <= 40) begin
            check_nominal(cyc);
            tick();
        end

        // Late acknowledge stretches the first gap until cycle 25.
        line_ack = 1'b0;
        start_frame();
        while (cyc <= 44) begin
            if (cyc == 15) check_val("late_ack line_done", line_done, 1'b1);
            if ((cyc >= 16) && (cyc <= 25)) begin
                check_val($sformatf("late_ack c%0d busy", cyc), busy, 1'b1);
                check_val($sformatf("late_ack c%0d tx_en", cyc), tx_en, 1'b0);
                check_val($sformatf("late_ack c%0d line_done", cyc), line_done, 1'b0);
            end
            if (cyc == 26) begin
                check_val("late_ack c26 tx_en", tx_en, 1'b1);
                check_val("late_ack c26 line_idx", line_idx, 8'd1);
            end
            if (cyc == 32) check_val("late_ack c32 start", start, 1'b1);
            if (cyc == 42) check_val("late_ack c42 busy", busy, 1'b1);
            if (cyc == 43) check_val("late_ack c43 frame_done", frame_done, 1'b1);
            if (cyc == 44) check_val("late_ack c44 busy", busy, 1'b0);
            if (cyc == 25) line_ack = 1'b1;
            tick();
        end

        // Acknowledge seen only during RX: GAP must hold indefinitely.
        line_ack = 1'b0;
        start_frame();
        while (cyc < 60) begin
            line_ack = (cyc == 9);
            if (cyc == 15) check_val("stuck line_done", line_done, 1'b1);
            if (cyc >= 16) check_val($sformatf("stuck c%0d tx_en", cyc), tx_en, 1'b0);
            tick();
        end
        check_val("stuck c60 busy", busy, 1'b1);
        check_val("stuck c60 start", start, 1'b0);
        check_val("stuck c60 line_idx", line_idx, 8'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_val("gap_abort aborted", aborted, 1'b1);
        check_val("gap_abort busy", busy, 1'b0);
        check_val("gap_abort line_done", line_done, 1'b0);
        tick();
        check_val("gap_abort pulse width", aborted, 1'b0);

        // Abort during RX at cycle 10.
        line_ack = 1'b1;
        start_frame();
        while (cyc < 10) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_val("rx_abort c11 aborted", aborted, 1'b1);
        check_val("rx_abort c11 start", start, 1'b0);
        check_val("rx_abort c11 we", dbf_lut_we, 1'b0);
        check_val("rx_abort c11 addr", dbf_lut_addr, 3'd0);
        check_val("rx_abort c11 busy", busy, 1'b0);
        check_val("rx_abort c11 line_done", line_done, 1'b0);
        while (cyc < 20) begin
            tick();
            check_all_zero($sformatf("rx_abort c%0d", cyc));
        end

        // Restart from line 0, with frame_start re-pulsed during RX.
        start_frame();
        while (cyc <= 40) begin
            frame_start = (cyc == 9);
            check_nominal(cyc);
            tick();
        end
        frame_start = 1'b0;

        // Abort on the last RX cycle suppresses line_done.
        start_frame();
        while (cyc < 14) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_val("eol_abort line_done", line_done, 1'b0);
        check_val("eol_abort aborted", aborted, 1'b1);
        check_val("eol_abort busy", busy, 1'b0);

        // Abort on the last GAP cycle of the frame suppresses frame_done.
        start_frame();
        while (cyc < 34) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_val("eof_abort frame_done", frame_done, 1'b0);
        check_val("eof_abort aborted", aborted, 1'b1);
        tick();
        check_val("eof_abort c36 frame_done", frame_done, 1'b0);

        // Asynchronous reset mid-TX.
        start_frame();
        tick();
        check_val("rst_tx c2 tx_en", tx_en, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            check_all_zero($sformatf("post_rst k%0d", k));
        end

        // abort together with frame_start in IDLE keeps the FSM idle.
        frame_start = 1'b1;
        abort       = 1'b1;
        tick();
        frame_start = 1'b0;
        abort       = 1'b0;
        check_all_zero("idle_abort_start");
        tick();
        check_all_zero("idle_abort_start next");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
